// File: rtl/pc_fetch_if.sv
// Fetch-side bus: combinational ROM port plus the valid/ready output slot toward decode.
// The master side (pc_fetch) drives the ROM address and the slot; the slave side is ROM + decode.
interface pc_fetch_if;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  modport master (
    output rom_addr,
    input  rom_data,
    output if_valid,
    input  if_ready,
    output if_pc,
    output if_instr
  );

  modport slave (
    input  rom_addr,
    output rom_data,
    input  if_valid,
    output if_ready,
    input  if_pc,
    input  if_instr
  );
endinterface

// File: rtl/pc_fetch.sv
// Instruction-fetch front end: PC register, ROM addressing, one-entry output slot,
// redirect/flush, sticky misaligned-target halt and a retired-fetch counter.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fetch_en,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  pc_fetch_if.master       bus,
  output logic             misalign_err,
  output logic [31:0]      err_pc,
  output logic [CNT_W-1:0] fetch_count
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t           r_state;
  state_t           w_next_state;

  logic [31:0]      r_pc;
  logic             r_valid;
  logic [31:0]      r_if_pc;
  logic [31:0]      r_if_instr;
  logic             r_err;
  logic [31:0]      r_err_pc;
  logic [CNT_W-1:0] r_count;

  logic             w_xfer;
  logic             w_slot_free;
  logic             w_misalign;
  logic             w_redirect;
  logic             w_capture;
  logic             w_valid_d;
  logic [31:0]      w_pc_d;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  assign w_xfer      = r_valid & bus.if_ready;
  assign w_slot_free = ~r_valid | bus.if_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= RUN;
    else        r_state <= w_next_state;
  end

  // Next-state logic: HALT is absorbing until reset
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      RUN:     if (redirect_valid && (redirect_pc[1:0] != 2'b00)) w_next_state = HALT;
      HALT:    w_next_state = HALT;
      default: w_next_state = HALT;
    endcase
  end

  // Output/control decode in priority order: misaligned, redirect, capture, stall
  always_comb begin
    w_misalign = 1'b0;
    w_redirect = 1'b0;
    w_capture  = 1'b0;
    w_valid_d  = r_valid;
    w_pc_d     = r_pc;
    case (r_state)
      RUN: begin
        if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
          w_misalign = 1'b1;
          w_valid_d  = 1'b0;
        end else if (redirect_valid) begin
          w_redirect = 1'b1;
          w_valid_d  = 1'b0;
          w_pc_d     = redirect_pc;
        end else if (fetch_en && w_slot_free) begin
          w_capture  = 1'b1;
          w_valid_d  = 1'b1;
          w_pc_d     = r_pc + 32'd4;
        end else if (w_xfer) begin
          w_valid_d  = 1'b0;
        end
      end
      default: begin
        w_valid_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_valid    <= 1'b0;
      r_if_pc    <= 32'h0;
      r_if_instr <= 32'h0;
      r_err      <= 1'b0;
      r_err_pc   <= 32'h0;
      r_count    <= '0;
    end else begin
      r_pc    <= w_pc_d;
      r_valid <= w_valid_d;
      if (w_capture) begin
        r_if_pc    <= r_pc;
        r_if_instr <= bus.rom_data;
      end
      if (w_misalign) begin
        r_err    <= 1'b1;
        r_err_pc <= redirect_pc;
      end
      // A handshake completing on a flush or halt edge still retires
      if (w_xfer) r_count <= r_count + CNT_ONE;
    end
  end

  assign bus.rom_addr = r_pc;
  assign bus.if_valid = r_valid;
  assign bus.if_pc    = r_if_pc;
  assign bus.if_instr = r_if_instr;
  assign misalign_err = r_err;
  assign err_pc       = r_err_pc;
  assign fetch_count  = r_count;

  a_slot_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (r_valid && !bus.if_ready && !redirect_valid && r_state == RUN)
      |=> (r_valid && $stable(r_if_pc) && $stable(r_if_instr)));

  a_halt_idle: assert property (@(posedge clk) disable iff (!rst_n)
    (r_state == HALT) |-> (!r_valid && $stable(r_pc)));

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch; ROM word at byte address 4*i holds i.
module tb_pc_fetch;
  logic        clk;
  logic        rst_n;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        misalign_err;
  logic [31:0] err_pc;
  logic [31:0] fetch_count;

  logic        fetch_en2;
  logic        redirect_valid2;
  logic [31:0] redirect_pc2;
  logic        misalign_err2;
  logic [31:0] err_pc2;
  logic [31:0] fetch_count2;

  int vectors;
  int miscompares;

  pc_fetch_if ifc ();
  pc_fetch_if ifc2 ();

  assign ifc.rom_data  = {2'b00, ifc.rom_addr[31:2]};
  assign ifc2.rom_data = {2'b00, ifc2.rom_addr[31:2]};

  pc_fetch #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .bus(ifc.master), .misalign_err(misalign_err), .err_pc(err_pc),
    .fetch_count(fetch_count)
  );

  pc_fetch #(.RESET_PC(32'hFFFF_FFF8), .CNT_W(32)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en2),
    .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2),
    .bus(ifc2.master), .misalign_err(misalign_err2), .err_pc(err_pc2),
    .fetch_count(fetch_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; ifc.if_ready = 1'b0;
    fetch_en2 = 1'b0; ifc2.if_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({ifc.if_valid, misalign_err} !== 2'b00 || ifc.if_pc !== 32'h0 || ifc.if_instr !== 32'h0 ||
        err_pc !== 32'h0 || fetch_count !== 32'h0 || ifc.rom_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_state got valid=%b err=%b pc=%h instr=%h err_pc=%h cnt=%0d addr=%h want all zero",
               ifc.if_valid, misalign_err, ifc.if_pc, ifc.if_instr, err_pc, fetch_count, ifc.rom_addr);
    end
    vectors++;
    if (ifc2.rom_addr !== 32'hFFFF_FFF8 || ifc2.if_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_pc_param got addr=%h valid=%b want FFFFFFF8 0", ifc2.rom_addr, ifc2.if_valid);
    end
  endtask

  task automatic test_stream();
    do_reset();
    fetch_en = 1'b1; ifc.if_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      vectors++;
      if (ifc.if_valid !== 1'b1 || ifc.if_pc !== 32'(4*k) || ifc.if_instr !== 32'(k) || fetch_count !== 32'(k)) begin
        miscompares++;
        $display("FAIL stream_%0d got valid=%b pc=%h instr=%h cnt=%0d want 1 %h %h %0d",
                 k, ifc.if_valid, ifc.if_pc, ifc.if_instr, fetch_count, 4*k, k, k);
      end
    end
    vectors++;
    if (ifc.rom_addr !== 32'd20) begin
      miscompares++;
      $display("FAIL stream_addr got %h want 00000014", ifc.rom_addr);
    end
    fetch_en = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (fetch_count !== 32'd5 || ifc.if_valid !== 1'b0 || ifc.rom_addr !== 32'd20) begin
      miscompares++;
      $display("FAIL stream_drain got cnt=%0d valid=%b addr=%h want 5 0 00000014",
               fetch_count, ifc.if_valid, ifc.rom_addr);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    fetch_en = 1'b1; ifc.if_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    ifc.if_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      vectors++;
      if (ifc.if_valid !== 1'b1 || ifc.if_pc !== 32'd8 || ifc.if_instr !== 32'd2 ||
          ifc.rom_addr !== 32'd12 || fetch_count !== 32'd2) begin
        miscompares++;
        $display("FAIL bp_hold_%0d got valid=%b pc=%h instr=%h addr=%h cnt=%0d want 1 8 2 c 2",
                 k, ifc.if_valid, ifc.if_pc, ifc.if_instr, ifc.rom_addr, fetch_count);
      end
    end
    ifc.if_ready = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (ifc.if_valid !== 1'b1 || ifc.if_pc !== 32'd12 || ifc.if_instr !== 32'd3 || fetch_count !== 32'd3) begin
      miscompares++;
      $display("FAIL bp_release got valid=%b pc=%h instr=%h cnt=%0d want 1 c 3 3",
               ifc.if_valid, ifc.if_pc, ifc.if_instr, fetch_count);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    fetch_en = 1'b1; ifc.if_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    vectors++;
    if (ifc.if_pc !== 32'd12 || ifc.if_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL redir_setup got pc=%h valid=%b want c 1", ifc.if_pc, ifc.if_valid);
    end
    ifc.if_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h100;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    vectors++;
    if (ifc.if_valid !== 1'b0 || ifc.rom_addr !== 32'h100 || fetch_count !== 32'd3) begin
      miscompares++;
      $display("FAIL redir_flush got valid=%b addr=%h cnt=%0d want 0 100 3",
               ifc.if_valid, ifc.rom_addr, fetch_count);
    end
    ifc.if_ready = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (ifc.if_valid !== 1'b1 || ifc.if_pc !== 32'h100 || ifc.if_instr !== 32'h40 || fetch_count !== 32'd3) begin
      miscompares++;
      $display("FAIL redir_target got valid=%b pc=%h instr=%h cnt=%0d want 1 100 40 3",
               ifc.if_valid, ifc.if_pc, ifc.if_instr, fetch_count);
    end
  endtask

  task automatic test_misalign();
    do_reset();
    fetch_en = 1'b1; ifc.if_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    vectors++;
    if (misalign_err !== 1'b1 || err_pc !== 32'h102 || ifc.if_valid !== 1'b0 ||
        fetch_count !== 32'd2 || ifc.rom_addr !== 32'd8) begin
      miscompares++;
      $display("FAIL misalign_set got err=%b err_pc=%h valid=%b cnt=%0d addr=%h want 1 102 0 2 8",
               misalign_err, err_pc, ifc.if_valid, fetch_count, ifc.rom_addr);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      vectors++;
      if (misalign_err !== 1'b1 || err_pc !== 32'h102 || ifc.if_valid !== 1'b0 ||
          ifc.rom_addr !== 32'd8 || fetch_count !== 32'd2) begin
        miscompares++;
        $display("FAIL halt_%0d got err=%b err_pc=%h valid=%b addr=%h cnt=%0d want 1 102 0 8 2",
                 k, misalign_err, err_pc, ifc.if_valid, ifc.rom_addr, fetch_count);
      end
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if (misalign_err !== 1'b0 || err_pc !== 32'h0 || ifc.rom_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL misalign_clear got err=%b err_pc=%h addr=%h want 0 0 0", misalign_err, err_pc, ifc.rom_addr);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (ifc.if_valid !== 1'b1 || ifc.if_pc !== 32'h0) begin
      miscompares++;
      $display("FAIL misalign_restart got valid=%b pc=%h want 1 0", ifc.if_valid, ifc.if_pc);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'hFFFF_FFF8; exp_pc[1] = 32'hFFFF_FFFC; exp_pc[2] = 32'h0000_0000;
    do_reset();
    fetch_en2 = 1'b1; ifc2.if_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      vectors++;
      if (ifc2.if_valid !== 1'b1 || ifc2.if_pc !== exp_pc[k] || ifc2.if_instr !== {2'b00, exp_pc[k][31:2]}) begin
        miscompares++;
        $display("FAIL wrap_%0d got valid=%b pc=%h instr=%h want 1 %h %h",
                 k, ifc2.if_valid, ifc2.if_pc, ifc2.if_instr, exp_pc[k], {2'b00, exp_pc[k][31:2]});
      end
    end
    fetch_en2 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      vectors++;
      if (ifc2.if_valid !== 1'b0 || fetch_count2 !== 32'd3 || ifc2.rom_addr !== 32'd4) begin
        miscompares++;
        $display("FAIL wrap_drain_%0d got valid=%b cnt=%0d addr=%h want 0 3 4",
                 k, ifc2.if_valid, fetch_count2, ifc2.rom_addr);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    fetch_en = 1'b1; ifc.if_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    vectors++;
    if (ifc.if_valid !== 1'b1 || fetch_count !== 32'd7 || ifc.if_pc !== 32'd28) begin
      miscompares++;
      $display("FAIL async_setup got valid=%b cnt=%0d pc=%h want 1 7 1c", ifc.if_valid, fetch_count, ifc.if_pc);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({ifc.if_valid, misalign_err} !== 2'b00 || ifc.if_pc !== 32'h0 || ifc.if_instr !== 32'h0 ||
        err_pc !== 32'h0 || fetch_count !== 32'h0 || ifc.rom_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL async_reset got valid=%b err=%b pc=%h instr=%h err_pc=%h cnt=%0d addr=%h want all zero",
               ifc.if_valid, misalign_err, ifc.if_pc, ifc.if_instr, err_pc, fetch_count, ifc.rom_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst_n = 1'b1;
    fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; ifc.if_ready = 1'b0;
    fetch_en2 = 1'b0; redirect_valid2 = 1'b0; redirect_pc2 = 32'h0; ifc2.if_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_misalign();
    test_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
